// File: rtl/tx_buffer_arbiter.sv
// tx_buffer_arbiter
//   Shares a fixed-latency transmit register pipeline among NUM_REQ requesters.
//   The block arbitrates round-robin and drives the pipeline input register.
//   A shadow tag pipeline follows every word through the transmit pipeline.
//   On the way out, each word is captured into a small output FIFO.
//   The FIFO is protected by credits, so it never overflows.
//   The transmit pipeline has no enable and no reset, so all flow control is here.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   enable        1 = new grants permitted; in-flight words and the FIFO still drain when 0
//   req_valid     per-requester word valid
//   req_data      per-requester word, requester i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot-or-zero grant (combinational)
//   buf_transmit  registered word into the transmit pipeline
//   buf_receive   word out of the transmit pipeline, PIPE_LAT cycles later
//   out_valid     FIFO non-empty
//   out_data      FIFO head word
//   out_src       FIFO head source index
//   out_ready     downstream accept
//   busy          words in flight or queued
//   overflow_err  sticky: push attempted while the FIFO was full
//
// PIPE_LAT must be >= 1 and FIFO_DEPTH >= PIPE_LAT+2 for full throughput.
module tx_buffer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 5,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           buf_transmit,
    input  logic [DATA_W-1:0]           buf_receive,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        overflow_err
);

    localparam int NTAG  = PIPE_LAT + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

    // Issue side
    logic [DATA_W-1:0] buf_transmit_q;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Tag stage k travels alongside buf_transmit delayed by k cycles.
    // The last stage therefore lines up with buf_receive.
    logic [NTAG-1:0]   tag_vld_q;
    logic [SRC_W-1:0]  tag_src_q [NTAG];

    // Output FIFO
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [SRC_W-1:0]  fifo_src_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              overflow_q;

    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  credit_used;
    logic              credit_ok;
    logic              pop, push_req, push, fifo_full;
    logic              found, issue;
    logic [SRC_W-1:0]  gnt_idx, cand;
    logic [DATA_W-1:0] gnt_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(NUM_REQ - 1)) ? '0 : s + SRC_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int k = 0; k < NTAG; k++) begin
            inflight = inflight + SUM_W'(tag_vld_q[k]);
        end
    end

    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign push_req  = tag_vld_q[NTAG-1];
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push      = push_req & (~fifo_full | pop);

    // Every word in flight already owns a FIFO slot.
    // The head leaving this cycle frees its slot in time for a new issue.
    assign credit_used = inflight + SUM_W'(fifo_cnt_q) - SUM_W'(pop);
    assign credit_ok   = enable & (credit_used < SUM_W'(FIFO_DEPTH));

    // Round-robin scan starting at rr_ptr_q.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
            cand = src_inc(cand);
        end
    end

    assign issue = found & credit_ok;

    always_comb begin
        req_ready = '0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                req_ready[i] = issue;
                gnt_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_d = issue ? src_inc(gnt_idx) : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_transmit_q <= '0;
            rr_ptr_q       <= '0;
            tag_vld_q      <= '0;
            for (int k = 0; k < NTAG; k++) begin
                tag_src_q[k] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            if (issue) begin
                buf_transmit_q <= gnt_data;
            end
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= {tag_vld_q[NTAG-2:0], issue};
            tag_src_q[0] <= gnt_idx;
            for (int k = 1; k < NTAG; k++) begin
                tag_src_q[k] <= tag_src_q[k-1];
            end

            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            end
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage holds only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= buf_receive;
            fifo_src_q[wr_ptr_q]  <= tag_src_q[NTAG-1];
        end
    end

    assign buf_transmit = buf_transmit_q;
    assign out_data     = fifo_data_q[rd_ptr_q];
    assign out_src      = fifo_src_q[rd_ptr_q];
    assign busy         = (|tag_vld_q) | out_valid;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_tx_buffer_arbiter.sv
// tb_tx_buffer_arbiter
//   Directed bench for tx_buffer_arbiter with default parameters.
//   A two-register model stands in for the transmit pipeline.
//   Inputs change 1 time unit after the rising edge.
//   Outputs are checked 1 time unit later, away from the edge.
module tb_tx_buffer_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req_valid;
    logic [19:0] req_data;
    logic [3:0]  req_ready;
    logic [4:0]  buf_transmit;
    logic [4:0]  buf_receive;
    logic        out_valid;
    logic [4:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        busy;
    logic        overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Transmit pipeline model: two plain registers with no reset.
    // They start holding garbage.
    logic [4:0] pipe_q1 = 5'h1F;
    logic [4:0] pipe_q2 = 5'h1E;
    always @(posedge clk) begin
        pipe_q1 <= buf_transmit;
        pipe_q2 <= pipe_q1;
    end
    assign buf_receive = pipe_q2;

    tx_buffer_arbiter #(
        .NUM_REQ(4), .DATA_W(5), .PIPE_LAT(2), .FIFO_DEPTH(4), .SRC_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .buf_transmit(buf_transmit), .buf_receive(buf_receive),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .busy(busy), .overflow_err(overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        enable    = 1'b0;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e4;
        logic [4:0] e5;
        int n_iss;
        int n_rx;

        rst_n    = 1'b1;
        req_data = '0;

        // Reset state
        do_reset();
        tick();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_buf_transmit", buf_transmit, 0);
        chk("rst_overflow", overflow_err, 0);

        // Single word from requester 2
        do_reset();
        tick();                                      // cycle 0
        enable = 1'b1; out_ready = 1'b1;
        req_valid = 4'b0100; req_data[10 +: 5] = 5'h15;
        #1;
        chk("t1_ready_c0", req_ready, 4'b0100);
        tick();                                      // cycle 1
        req_valid = '0;
        #1;
        chk("t1_buf_tx", buf_transmit, 5'h15);
        chk("t1_busy_c1", busy, 1);
        chk("t1_ovalid_c1", out_valid, 0);
        tick(); tick();                              // cycle 3
        #1;
        chk("t1_ovalid_c3", out_valid, 0);
        tick();                                      // cycle 4
        #1;
        chk("t1_ovalid_c4", out_valid, 1);
        chk("t1_odata_c4", out_data, 5'h15);
        chk("t1_osrc_c4", out_src, 2);
        tick();                                      // cycle 5
        #1;
        chk("t1_ovalid_c5", out_valid, 0);
        chk("t1_busy_c5", busy, 0);

        // Round-robin with all four requesters always valid
        do_reset();
        tick();
        enable = 1'b1; out_ready = 1'b1;
        req_data = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int c = 0; c <= 14; c++) begin
            req_valid = (c < 10) ? 4'hF : 4'h0;
            #1;
            e4 = (c < 10) ? (4'b0001 << (c % 4)) : 4'b0000;
            chk($sformatf("t2_ready_c%0d", c), req_ready, e4);
            if (c >= 4 && c < 14) begin
                chk($sformatf("t2_ovalid_c%0d", c), out_valid, 1);
                chk($sformatf("t2_osrc_c%0d", c), out_src, (c - 4) % 4);
                chk($sformatf("t2_odata_c%0d", c), out_data, ((c - 4) % 4) + 1);
            end
            if (c == 14) begin
                chk("t2_ovalid_end", out_valid, 0);
                chk("t2_busy_end", busy, 0);
            end
            tick();
        end

        // Backpressure on requester 1
        do_reset();
        tick();
        enable = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            req_valid = (c < 12) ? 4'b0010 : 4'b0000;
            req_data[5 +: 5] = 5'h10 + 5'(c);
            out_ready = (c == 8 || c >= 12);
            #1;
            e4 = (c <= 3 || c == 8) ? 4'b0010 : 4'b0000;
            chk($sformatf("t3_ready_c%0d", c), req_ready, e4);
            case (c)
                7: begin
                    chk("t3_ovalid_full", out_valid, 1);
                    chk("t3_head_c7", out_data, 5'h10);
                    chk("t3_busy_full", busy, 1);
                    chk("t3_ovf_c7", overflow_err, 0);
                end
                9:  chk("t3_head_c9", out_data, 5'h11);
                11: chk("t3_ovf_c11", overflow_err, 0);
                12: chk("t3_drain0", out_data, 5'h11);
                13: chk("t3_drain1", out_data, 5'h12);
                14: chk("t3_drain2", out_data, 5'h13);
                15: begin
                    chk("t3_drain3", out_data, 5'h18);
                    chk("t3_drain3_src", out_src, 1);
                end
                16: begin
                    chk("t3_ovalid_end", out_valid, 0);
                    chk("t3_busy_end", busy, 0);
                    chk("t3_ovf_end", overflow_err, 0);
                end
                default: ;
            endcase
            tick();
        end

        // Enable gating
        do_reset();
        tick();
        out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            req_valid = 4'b0001;
            req_data[0 +: 5] = 5'h07 + 5'(c);
            enable = (c < 2);
            #1;
            e4 = (c < 2) ? 4'b0001 : 4'b0000;
            chk($sformatf("t4_ready_c%0d", c), req_ready, e4);
            if (c == 4) begin
                chk("t4_ovalid_c4", out_valid, 1);
                chk("t4_odata_c4", out_data, 5'h07);
            end
            if (c == 5) begin
                chk("t4_ovalid_c5", out_valid, 1);
                chk("t4_odata_c5", out_data, 5'h08);
            end
            if (c == 6) begin
                chk("t4_ovalid_c6", out_valid, 0);
                chk("t4_busy_c6", busy, 0);
            end
            tick();
        end

        // Reset mid-flight
        do_reset();
        tick();
        enable = 1'b1; out_ready = 1'b1;
        req_valid = 4'b0010; req_data[5 +: 5] = 5'h1C;
        #1;
        chk("t5_ready_c0", req_ready, 4'b0010);
        tick();
        #1;
        chk("t5_ready_c1", req_ready, 4'b0010);
        tick();                                      // cycle 2
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_ovalid_rst", out_valid, 0);
        chk("t5_buftx_rst", buf_transmit, 0);
        tick();
        #1 chk("t5_ovalid_c3", out_valid, 0);
        tick();
        #1 chk("t5_ovalid_c4", out_valid, 0);
        tick();                                      // cycle 5
        #1 rst_n = 1'b1;
        for (int c = 6; c <= 8; c++) begin
            tick();
            #1;
            chk($sformatf("t5_ovalid_c%0d", c), out_valid, 0);
            chk($sformatf("t5_busy_c%0d", c), busy, 0);
        end
        tick();
        req_valid = 4'b1010;
        #1;
        chk("t5_ready_after", req_ready, 4'b0010);
        tick();
        req_valid = '0;

        // Wrap-around stream from requester 3
        do_reset();
        tick();
        enable = 1'b1;
        n_iss = 0;
        n_rx  = 0;
        for (int c = 0; c < 200 && n_rx < 12; c++) begin
            req_valid = (n_iss < 12) ? 4'b1000 : 4'b0000;
            req_data[15 +: 5] = 5'h03 + 5'(n_iss);
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                e5 = 5'h03 + 5'(n_rx);
                chk($sformatf("t6_data_%0d", n_rx), out_data, e5);
                chk($sformatf("t6_src_%0d", n_rx), out_src, 3);
                n_rx++;
            end
            if (req_ready[3]) n_iss++;
            tick();
        end
        chk("t6_rx_count", n_rx, 12);
        chk("t6_overflow", overflow_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
